fastica_update_stream: RTL

Streaming, parametrised FastICA one-unit weight-update engine. Given a weight vector w and M whitened N-channel samples z, it computes w+ = mean(z·g(y)) − beta·w, with y = wᵀz and g(y) = y³. Samples are accepted over a valid/ready handshake rather than a full sample array. The block sits between the whitening buffer and the Gram-Schmidt/normalisation stage, and uses the same signed fixed-point format.

---
 rtl/fastica_pkg.sv | 31 +++
 rtl/fxp_mul_sat.sv | 22 ++
 rtl/fastica_update_stream.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fastica_pkg.sv
// Shared types and helpers for the streaming FastICA weight-update engine.
package fastica_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DOT,
    ST_CUBE,
    ST_ACC,
    ST_BETA,
    ST_OUT,
    ST_DONE
  } state_t;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_EST   = 1'b1;

  // Integer part of the fixed beta; the top scales it by 2^FRAC_WIDTH.
  localparam int BETA_FIXED = 3;

  function automatic logic signed [63:0] saturate(input logic signed [63:0] x, input int dw);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (dw - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/fxp_mul_sat.sv
// Signed fixed-point multiply: (a*b) >>> FW, clamped to DW bits with overflow flag.
module fxp_mul_sat
  import fastica_pkg::*;
#(
  parameter int DW = 16,
  parameter int FW = 10
) (
  input  logic signed [DW-1:0] a,
  input  logic signed [DW-1:0] b,
  output logic signed [DW-1:0] p,
  output logic                 ovf
);

  logic signed [2*DW-1:0] prod;
  logic signed [2*DW-1:0] scaled;

  assign prod   = (2*DW)'(a) * (2*DW)'(b);
  assign scaled = prod >>> FW;
  assign p      = DW'(saturate(64'(scaled), DW));
  assign ovf    = (64'(p) != 64'(scaled));

endmodule

// File: rtl/fastica_update_stream.sv
// One-unit FastICA update w+ = mean(z*y^3) - beta*w over a stream of M samples,
// sharing a single saturating multiplier across all arithmetic phases.
//
// state | meaning
// IDLE  | waiting for start; start latches w and mode, clears accumulators
// LOAD  | in_ready high; handshake captures one sample
// DOT   | N cycles, y += w_k*z_k
// CUBE  | 2 cycles, y2 = y*y (S2 += y2), then y3 = y2*y
// ACC   | N cycles, P_k += z_k*y3; last lane picks LOAD or BETA
// BETA  | 1 cycle, select fixed or estimated beta
// OUT   | N cycles, w_out_k = P_k/M - beta*w_k
// DONE  | 1 cycle, arms the registered out_valid pulse
module fastica_update_stream
  import fastica_pkg::*;
#(
  parameter int N          = 7,
  parameter int M          = 1024,
  parameter int LOGM       = $clog2(M),
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_WIDTH = 10,
  parameter int ACC_WIDTH  = DATA_WIDTH + LOGM
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       mode,
  input  logic [N*DATA_WIDTH-1:0]    w_in,
  input  logic [N*DATA_WIDTH-1:0]    z_in,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       busy,
  output logic [N*DATA_WIDTH-1:0]    w_out,
  output logic                       out_valid,
  output logic                       sat_flag
);

  localparam int DW = DATA_WIDTH;
  localparam int KW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (LOGM > 0) ? LOGM : 1;
  localparam logic signed [DW-1:0] BETA_FIXED_Q = DW'(BETA_FIXED <<< FRAC_WIDTH);

  state_t state, state_next;
  logic [KW-1:0] k;
  logic [CW-1:0] samples_left;
  logic          mode_reg;
  logic          last_lane;

  logic signed [DW-1:0]        w_reg [N];
  logic signed [DW-1:0]        z_reg [N];
  logic signed [ACC_WIDTH-1:0] p_acc [N];
  logic signed [ACC_WIDTH-1:0] s2;
  logic signed [DW-1:0]        y, y2, y3, beta;

  logic signed [DW-1:0] mul_a, mul_b, mul_p;
  logic                 mul_ovf;
  logic signed [63:0]   dot_sum, out_diff, beta_est;
  logic signed [DW-1:0] dot_sat, out_sat, beta_sat;
  logic                 dot_ovf, out_ovf, beta_ovf;
  logic                 sat_hit;

  fxp_mul_sat #(.DW(DW), .FW(FRAC_WIDTH)) u_mul (
    .a   (mul_a),
    .b   (mul_b),
    .p   (mul_p),
    .ovf (mul_ovf)
  );

  assign last_lane = (k == KW'(N - 1));
  assign in_ready  = (state == ST_LOAD);
  assign busy      = (state != ST_IDLE);

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state)
      ST_DOT:  begin mul_a = w_reg[k];                 mul_b = z_reg[k]; end
      ST_CUBE: begin mul_a = (k == '0) ? y : y2;       mul_b = y;        end
      ST_ACC:  begin mul_a = z_reg[k];                 mul_b = y3;       end
      ST_OUT:  begin mul_a = beta;                     mul_b = w_reg[k]; end
      default: ;
    endcase
  end

  assign dot_sum  = 64'(y) + 64'(mul_p);
  assign dot_sat  = DW'(saturate(dot_sum, DW));
  assign dot_ovf  = (64'(dot_sat) != dot_sum);

  assign out_diff = 64'(p_acc[k] >>> LOGM) - 64'(mul_p);
  assign out_sat  = DW'(saturate(out_diff, DW));
  assign out_ovf  = (64'(out_sat) != out_diff);

  assign beta_est = 64'(s2 >>> LOGM) * 64'sd3;
  assign beta_sat = DW'(saturate(beta_est, DW));
  assign beta_ovf = (64'(beta_sat) != beta_est);

  always_comb begin
    sat_hit = 1'b0;
    case (state)
      ST_DOT:  sat_hit = mul_ovf | dot_ovf;
      ST_CUBE: sat_hit = mul_ovf;
      ST_ACC:  sat_hit = mul_ovf;
      ST_BETA: sat_hit = (mode_reg == MODE_EST) && beta_ovf;
      ST_OUT:  sat_hit = mul_ovf | out_ovf;
      default: ;
    endcase
  end

  // out_valid is registered, so a start landing on the pulse must be masked.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start && !out_valid) state_next = ST_LOAD;
      ST_LOAD: if (in_valid) state_next = ST_DOT;
      ST_DOT:  if (last_lane) state_next = ST_CUBE;
      ST_CUBE: if (k != '0) state_next = ST_ACC;
      ST_ACC:  if (last_lane) state_next = (samples_left == '0) ? ST_BETA : ST_LOAD;
      ST_BETA: state_next = ST_OUT;
      ST_OUT:  if (last_lane) state_next = ST_DONE;
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      k            <= '0;
      samples_left <= '0;
      mode_reg     <= MODE_FIXED;
      y            <= '0;
      y2           <= '0;
      y3           <= '0;
      beta         <= '0;
      s2           <= '0;
      w_out        <= '0;
      out_valid    <= 1'b0;
      sat_flag     <= 1'b0;
      for (int i = 0; i < N; i++) begin
        w_reg[i] <= '0;
        z_reg[i] <= '0;
        p_acc[i] <= '0;
      end
    end else begin
      state     <= state_next;
      k         <= (state_next != state) ? '0 : k + KW'(1);
      out_valid <= (state == ST_DONE);
      if (sat_hit) sat_flag <= 1'b1;
      case (state)
        ST_IDLE: begin
          if (state_next == ST_LOAD) begin
            mode_reg     <= mode;
            s2           <= '0;
            samples_left <= CW'(M - 1);
            sat_flag     <= 1'b0;
            for (int i = 0; i < N; i++) begin
              w_reg[i] <= w_in[i*DW +: DW];
              p_acc[i] <= '0;
            end
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            y <= '0;
            for (int i = 0; i < N; i++) z_reg[i] <= z_in[i*DW +: DW];
          end
        end
        ST_DOT: y <= dot_sat;
        ST_CUBE: begin
          if (k == '0) begin
            y2 <= mul_p;
            s2 <= s2 + ACC_WIDTH'(mul_p);
          end else begin
            y3 <= mul_p;
          end
        end
        ST_ACC: begin
          p_acc[k] <= p_acc[k] + ACC_WIDTH'(mul_p);
          if (last_lane) samples_left <= samples_left - CW'(1);
        end
        ST_BETA: begin
          case (mode_reg)
            MODE_FIXED: beta <= BETA_FIXED_Q;
            MODE_EST:   beta <= beta_sat;
            default:    beta <= BETA_FIXED_Q;
          endcase
        end
        ST_OUT: w_out[k*DW +: DW] <= out_sat;
        default: ;
      endcase
    end
  end

endmodule
